// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: shared mode encodings for the universal shift register
package univ_shift_reg_pkg;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
endpackage

// File: rtl/shift_frame_counter.sv
// shift_frame_counter: counts shifts per frame, pulses frame_done on the WIDTH-th shift
module shift_frame_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             clear,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             wrap;
  always_comb begin
    wrap   = cnt_q == CNT_W'(WIDTH - 1);
    cnt_d  = clear ? '0 : shift ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
    done_d = shift && !clear && wrap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end
  assign bit_cnt    = cnt_q;
  assign frame_done = done_q;
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with hold, shift right/left, load and frame counter
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] parallel_out,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic [1:0]       act;
  logic             shift, clear;
  always_comb begin
    act   = en ? mode : MODE_HOLD;
    q_d   = act == MODE_SHR  ? {serial_in, q_q[WIDTH-1:1]} :
            act == MODE_SHL  ? {q_q[WIDTH-2:0], serial_in} :
            act == MODE_LOAD ? parallel_in : q_q;
    so_d  = act == MODE_SHR ? q_q[0] : act == MODE_SHL ? q_q[WIDTH-1] : so_q;
    shift = act == MODE_SHR || act == MODE_SHL;
    clear = act == MODE_LOAD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q  <= RESET_VAL;
      so_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      so_q <= so_d;
    end
  end
  shift_frame_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .shift     (shift),
    .clear     (clear),
    .bit_cnt   (bit_cnt),
    .frame_done(frame_done)
  );
  assign parallel_out = q_q;
  assign serial_out   = so_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed and randomized checks of univ_shift_reg against an arithmetic model
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;
  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, serial_in = 1'b0;
  logic [1:0] mode = MODE_HOLD;
  logic [7:0] parallel_in = '0, parallel_out;
  logic       serial_out, frame_done;
  logic [2:0] bit_cnt;
  int n_chk = 0, n_fail = 0;
  int m_q = 0, m_so = 0, m_n = 0, m_done = 0;
  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .serial_in   (serial_in),
    .parallel_in (parallel_in),
    .serial_out  (serial_out),
    .parallel_out(parallel_out),
    .bit_cnt     (bit_cnt),
    .frame_done  (frame_done)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic e, input logic [1:0] md, input logic si, input logic [7:0] pi);
    rst = r;
    en = e;
    mode = md;
    serial_in = si;
    parallel_in = pi;
    @(posedge clk);
    #1;
    if (r) begin
      m_q = 0; m_so = 0; m_n = 0; m_done = 0;
    end else if (!e || md == MODE_HOLD) begin
      m_done = 0;
    end else if (md == MODE_SHR) begin
      m_so = m_q % 2;
      m_q = m_q / 2 + 128 * int'(si);
      m_n++;
      m_done = (m_n % 8 == 0) ? 1 : 0;
    end else if (md == MODE_SHL) begin
      m_so = m_q / 128;
      m_q = (m_q * 2) % 256 + int'(si);
      m_n++;
      m_done = (m_n % 8 == 0) ? 1 : 0;
    end else begin
      m_q = int'(pi); m_n = 0; m_done = 0;
    end
  endtask
  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      step(1, 1, MODE_LOAD, 1, 8'hFF);
      n_chk++; if (parallel_out !== 8'h00) begin n_fail++; $display("FAIL reset_q got %h exp 00", parallel_out); end
      n_chk++; if (serial_out !== 1'b0) begin n_fail++; $display("FAIL reset_so got %b exp 0", serial_out); end
      n_chk++; if (bit_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", bit_cnt); end
      n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b exp 0", frame_done); end
    end
  endtask
  task automatic test_shift_right;
    logic [7:0] exp_seq;
    exp_seq = 8'b10100101;
    step(0, 1, MODE_LOAD, 0, 8'hA5);
    n_chk++; if (parallel_out !== 8'hA5) begin n_fail++; $display("FAIL shr_load got %h exp a5", parallel_out); end
    for (int k = 0; k < 8; k++) begin
      step(0, 1, MODE_SHR, 0, 8'h00);
      n_chk++; if (serial_out !== exp_seq[7-k]) begin n_fail++; $display("FAIL shr_so[%0d] got %b exp %b", k, serial_out, exp_seq[7-k]); end
      n_chk++; if (frame_done !== (k == 7)) begin n_fail++; $display("FAIL shr_fd[%0d] got %b exp %b", k, frame_done, k == 7); end
    end
    n_chk++; if (parallel_out !== 8'h00) begin n_fail++; $display("FAIL shr_final got %h exp 00", parallel_out); end
  endtask
  task automatic test_shift_left;
    logic [7:0] exp_seq;
    int pulses;
    exp_seq = 8'b00111100;
    pulses = 0;
    step(0, 1, MODE_LOAD, 0, 8'h3C);
    for (int k = 0; k < 8; k++) begin
      step(0, 1, MODE_SHL, 1, 8'h00);
      pulses += int'(frame_done);
      n_chk++; if (serial_out !== exp_seq[7-k]) begin n_fail++; $display("FAIL shl_so[%0d] got %b exp %b", k, serial_out, exp_seq[7-k]); end
    end
    n_chk++; if (parallel_out !== 8'hFF) begin n_fail++; $display("FAIL shl_final got %h exp ff", parallel_out); end
    n_chk++; if (pulses != 1) begin n_fail++; $display("FAIL shl_pulses got %0d exp 1", pulses); end
  endtask
  task automatic test_siso;
    logic [4:0] pat;
    logic si, exp_so;
    pat = 5'b01101;
    step(1, 0, MODE_HOLD, 0, 8'h00);
    for (int k = 0; k < 16; k++) begin
      si = (k < 5) ? pat[k] : 1'b0;
      exp_so = (k >= 8 && k < 13) ? pat[k-8] : 1'b0;
      step(0, 1, MODE_SHR, si, 8'h00);
      n_chk++; if (serial_out !== exp_so) begin n_fail++; $display("FAIL siso_so[%0d] got %b exp %b", k + 1, serial_out, exp_so); end
      n_chk++; if (frame_done !== (k == 7 || k == 15)) begin n_fail++; $display("FAIL siso_fd[%0d] got %b exp %b", k + 1, frame_done, k == 7 || k == 15); end
    end
  endtask
  task automatic test_hold;
    logic [7:0] q0;
    logic so0;
    step(1, 0, MODE_HOLD, 0, 8'h00);
    step(0, 1, MODE_LOAD, 0, 8'h96);
    for (int k = 0; k < 3; k++) step(0, 1, MODE_SHL, 1, 8'h00);
    q0 = parallel_out;
    so0 = serial_out;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) step(0, 0, MODE_SHR, 1, 8'hFF);
      else step(0, 1, MODE_HOLD, 1, 8'hFF);
      n_chk++; if (parallel_out !== q0 || parallel_out !== 8'(m_q)) begin n_fail++; $display("FAIL hold_q[%0d] got %h exp %h", k, parallel_out, 8'(m_q)); end
      n_chk++; if (serial_out !== so0) begin n_fail++; $display("FAIL hold_so[%0d] got %b exp %b", k, serial_out, so0); end
      n_chk++; if (bit_cnt !== 3'd3) begin n_fail++; $display("FAIL hold_cnt[%0d] got %0d exp 3", k, bit_cnt); end
      n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL hold_fd[%0d] got %b exp 0", k, frame_done); end
    end
    for (int k = 3; k < 8; k++) begin
      step(0, 1, (k % 2) ? MODE_SHR : MODE_SHL, 0, 8'h00);
      n_chk++; if (frame_done !== (k == 7)) begin n_fail++; $display("FAIL hold_resume_fd[%0d] got %b exp %b", k + 1, frame_done, k == 7); end
    end
  endtask
  task automatic test_reset_mid;
    step(1, 0, MODE_HOLD, 0, 8'h00);
    for (int k = 0; k < 5; k++) step(0, 1, MODE_SHR, 1, 8'h00);
    step(1, 1, MODE_SHR, 1, 8'h00);
    n_chk++; if (bit_cnt !== 3'd0) begin n_fail++; $display("FAIL rstmid_cnt got %0d exp 0", bit_cnt); end
    for (int k = 0; k < 8; k++) begin
      step(0, 1, MODE_SHR, 1, 8'h00);
      n_chk++; if (frame_done !== (k == 7)) begin n_fail++; $display("FAIL rstmid_fd[%0d] got %b exp %b", k + 1, frame_done, k == 7); end
    end
  endtask
  task automatic test_load_mid;
    for (int k = 0; k < 6; k++) step(0, 1, MODE_SHL, 0, 8'h00);
    step(0, 1, MODE_LOAD, 1, 8'h0F);
    n_chk++; if (bit_cnt !== 3'd0) begin n_fail++; $display("FAIL ldmid_cnt got %0d exp 0", bit_cnt); end
    n_chk++; if (parallel_out !== 8'h0F) begin n_fail++; $display("FAIL ldmid_q got %h exp 0f", parallel_out); end
    for (int k = 0; k < 8; k++) begin
      step(0, 1, MODE_SHL, 0, 8'h00);
      n_chk++; if (frame_done !== (k == 7)) begin n_fail++; $display("FAIL ldmid_fd[%0d] got %b exp %b", k + 1, frame_done, k == 7); end
    end
  endtask
  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom));
      n_chk++; if (parallel_out !== 8'(m_q)) begin n_fail++; $display("FAIL rnd_q[%0d] got %h exp %h", i, parallel_out, 8'(m_q)); end
      n_chk++; if (serial_out !== 1'(m_so)) begin n_fail++; $display("FAIL rnd_so[%0d] got %b exp %0d", i, serial_out, m_so); end
      n_chk++; if (bit_cnt !== 3'(m_n % 8)) begin n_fail++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", i, bit_cnt, m_n % 8); end
      n_chk++; if (frame_done !== 1'(m_done)) begin n_fail++; $display("FAIL rnd_fd[%0d] got %b exp %0d", i, frame_done, m_done); end
    end
  endtask
  initial begin
    test_reset;
    test_shift_right;
    test_shift_left;
    test_siso;
    test_hold;
    test_reset_mid;
    test_load_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
